// File: rtl/draw_arb_pkg.sv
// rtl/draw_arb_pkg.sv - shared constants for the draw engine arbiter
package draw_arb_pkg;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_XW             = 8;
    localparam int DEF_YW             = 7;
    localparam int DEF_CW             = 3;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] IDLE    = 3'd0;
    localparam logic [ST_W-1:0] LAUNCH  = 3'd1;
    localparam logic [ST_W-1:0] RELEASE = 3'd2;
    localparam logic [ST_W-1:0] ACK     = 3'd3;
    localparam logic [ST_W-1:0] ABORT   = 3'd4;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// rtl/draw_arbiter_rr_picker.sv - combinational round-robin winner select
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx,
    output logic             any
);

    // Scan from rr_ptr upward, wrapping, and keep the first set request.
    always_comb begin : pick
        int idx;
        idx        = 0;
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin sharing of the draw engine; watchdog under DRAW_ARB_TIMEOUT_EN
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int XW             = DEF_XW,
    parameter int YW             = DEF_YW,
    parameter int CW             = DEF_CW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*XW-1:0] req_x,
    input  logic [N_REQ*YW-1:0] req_y,
    input  logic [N_REQ*CW-1:0] req_colour,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    grant,
    output logic                busy,
    output logic                eng_go,
    output logic [XW-1:0]       eng_x,
    output logic [YW-1:0]       eng_y,
    output logic [CW-1:0]       eng_colour,
    input  logic                eng_done,
    output logic                err
);

    localparam int IW = $clog2(N_REQ);

    logic [ST_W-1:0]  state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             eng_go_q, eng_go_d;
    logic [XW-1:0]    eng_x_q, eng_x_d;
    logic [YW-1:0]    eng_y_q, eng_y_d;
    logic [CW-1:0]    eng_colour_q, eng_colour_d;

`ifdef DRAW_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    logic [N_REQ-1:0] pick_winner;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Transaction sequencer: grant and latch, go/done handshake, then one-cycle ack.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        ack_d        = '0;
        rr_ptr_d     = rr_ptr_q;
        eng_go_d     = eng_go_q;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        eng_colour_d = eng_colour_q;
`ifdef DRAW_ARB_TIMEOUT_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d      = LAUNCH;
                    grant_d      = pick_winner;
                    grant_idx_d  = pick_idx;
                    eng_go_d     = 1'b1;
                    eng_x_d      = req_x[pick_idx*XW +: XW];
                    eng_y_d      = req_y[pick_idx*YW +: YW];
                    eng_colour_d = req_colour[pick_idx*CW +: CW];
                end
            end
            LAUNCH: begin
                if (eng_done) begin
                    state_d  = RELEASE;
                    eng_go_d = 1'b0;
                end
`ifdef DRAW_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d  = ABORT;
                    eng_go_d = 1'b0;
                    err_d    = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!eng_done) begin
                    state_d = ACK;
                    ack_d   = grant_q;
                end
`ifdef DRAW_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                end
`endif
            end
`ifdef DRAW_ARB_TIMEOUT_EN
            // The requester is still released after a hung engine.
            ABORT: begin
                state_d = ACK;
                ack_d   = grant_q;
            end
`endif
            ACK: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (grant_idx_q == IW'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                eng_go_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef DRAW_ARB_TIMEOUT_EN
    // Watchdog counts time spent in one handshake state; any state change restarts it.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == LAUNCH) || (state_q == RELEASE))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // No watchdog: the comparison is constant false, so err is tied low.
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    // State and output registers; reset drops eng_go without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            ack_q        <= '0;
            rr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            eng_go_q     <= 1'b0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            eng_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            ack_q        <= ack_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            eng_go_q     <= eng_go_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            eng_colour_q <= eng_colour_d;
        end
    end

    assign ack        = ack_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign eng_go     = eng_go_q;
    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
    assign eng_colour = eng_colour_q;

endmodule
